spi_frame_slave: RTL and testbench

- SPI slave front end for the floating-point ALU system; sits directly upstream of the ALU datapath inside System_Top.
- Deserialises a 64-bit MSB-first frame from SPI_PICO into two 32-bit IEEE-754 operands and presents them with a one-cycle valid strobe and the latched opcode.
- Concurrently shifts out on SPI_POCI the most recent ALU result captured before the frame started, as {32'h0, result}.

---
 rtl/spi_frame_slave.sv | 177 +++++++++++++++++
 tb/tb_spi_frame_slave.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/spi_frame_slave.sv
// SPI mode-0 frame slave: 64-bit MSB-first frame -> two operands + latched opcode; returns last ALU result on POCI.
// Latency: frame_valid SYNC_STAGES+2 clocks after the 64th SPI_CLK pin rise; no backpressure (strobes are one-shot).
module spi_frame_slave #(
  parameter int FRAME_BITS  = 64,
  parameter int SYNC_STAGES = 2
) (
  input  logic                    sys_clock,
  input  logic                    reset,
  input  logic                    SPI_CLK,
  input  logic                    SPI_PICO,
  input  logic                    SPI_CS,
  output logic                    SPI_POCI,
  input  logic [2:0]              opcode,
  input  logic                    result_valid,
  input  logic [FRAME_BITS/2-1:0] result_data,
  output logic [FRAME_BITS/2-1:0] operand_a,
  output logic [FRAME_BITS/2-1:0] operand_b,
  output logic [2:0]              op_sel,
  output logic                    frame_valid,
  output logic                    frame_error,
  output logic                    busy
);
  localparam int OPW = FRAME_BITS / 2;
  localparam int CW  = $clog2(FRAME_BITS + 1);

  typedef enum logic [1:0] {WAIT_CS_HIGH, IDLE, SHIFT, DONE} state_t;

  state_t                      state_q, state_d;
  logic [SYNC_STAGES-1:0]      sclk_q, sclk_d, scs_q, scs_d, spico_q, spico_d;
  logic [SYNC_STAGES-1:0][2:0] sop_q, sop_d;
  logic                        sclk_prev_q, sclk_prev_d, scs_prev_q, scs_prev_d;
  logic [OPW-1:0]              result_q, result_d;
  logic [FRAME_BITS-1:0]       tx_q, tx_d, rx_q, rx_d;
  logic [CW-1:0]               cnt_q, cnt_d;
  logic                        poci_q, poci_d;
  logic [OPW-1:0]              operand_a_q, operand_a_d, operand_b_q, operand_b_d;
  logic [2:0]                  op_sel_q, op_sel_d;
  logic                        frame_valid_q, frame_valid_d, frame_error_q, frame_error_d;
  logic                        busy_q, busy_d;

  logic sclk_s, scs_s, spico_s;
  logic clk_rise, clk_fall, cs_rise, cs_fall;

  assign sclk_s   = sclk_q[SYNC_STAGES-1];
  assign scs_s    = scs_q[SYNC_STAGES-1];
  assign spico_s  = spico_q[SYNC_STAGES-1];
  assign clk_rise = sclk_s & ~sclk_prev_q;
  assign clk_fall = ~sclk_s & sclk_prev_q;
  assign cs_rise  = scs_s & ~scs_prev_q;
  assign cs_fall  = ~scs_s & scs_prev_q;

  always_comb begin
    sclk_d        = {sclk_q[SYNC_STAGES-2:0], SPI_CLK};
    scs_d         = {scs_q[SYNC_STAGES-2:0], SPI_CS};
    spico_d       = {spico_q[SYNC_STAGES-2:0], SPI_PICO};
    sop_d         = {sop_q[SYNC_STAGES-2:0], opcode};
    sclk_prev_d   = sclk_s;
    scs_prev_d    = scs_s;
    // A result arriving on the CS-fall cycle is forwarded into the tx load.
    result_d      = result_valid ? result_data : result_q;
    state_d       = state_q;
    tx_d          = tx_q;
    rx_d          = rx_q;
    cnt_d         = cnt_q;
    poci_d        = poci_q;
    operand_a_d   = operand_a_q;
    operand_b_d   = operand_b_q;
    op_sel_d      = op_sel_q;
    frame_valid_d = 1'b0;
    frame_error_d = 1'b0;
    busy_d        = busy_q;

    case (state_q)
      WAIT_CS_HIGH: begin
        busy_d = 1'b0;
        poci_d = 1'b0;
        if (scs_s) state_d = IDLE;
      end
      IDLE: begin
        busy_d = 1'b0;
        poci_d = 1'b0;
        if (cs_fall) begin
          tx_d    = {{(FRAME_BITS-OPW){1'b0}}, result_d};
          poci_d  = tx_d[FRAME_BITS-1];
          cnt_d   = '0;
          busy_d  = 1'b1;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (cnt_q == CW'(FRAME_BITS)) begin
          operand_a_d   = rx_q[FRAME_BITS-1:OPW];
          operand_b_d   = rx_q[OPW-1:0];
          op_sel_d      = sop_q[SYNC_STAGES-1];
          frame_valid_d = 1'b1;
          poci_d        = 1'b0;
          busy_d        = ~cs_rise;
          state_d       = cs_rise ? IDLE : DONE;
        end else if (cs_rise) begin
          // CS release takes priority over any coincident SPI_CLK edge.
          frame_error_d = 1'b1;
          poci_d        = 1'b0;
          busy_d        = 1'b0;
          state_d       = IDLE;
        end else begin
          if (clk_rise) begin
            rx_d  = {rx_q[FRAME_BITS-2:0], spico_s};
            cnt_d = cnt_q + CW'(1);
          end
          if (clk_fall) begin
            tx_d   = {tx_q[FRAME_BITS-2:0], 1'b0};
            poci_d = tx_d[FRAME_BITS-1];
          end
        end
      end
      DONE: begin
        poci_d = 1'b0;
        if (cs_rise) begin
          busy_d  = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = WAIT_CS_HIGH;
    endcase
  end

  always_ff @(posedge sys_clock) begin
    if (reset) begin
      state_q       <= WAIT_CS_HIGH;
      sclk_q        <= '0;
      scs_q         <= '0;
      spico_q       <= '0;
      sop_q         <= '0;
      sclk_prev_q   <= 1'b0;
      scs_prev_q    <= 1'b0;
      result_q      <= '0;
      tx_q          <= '0;
      rx_q          <= '0;
      cnt_q         <= '0;
      poci_q        <= 1'b0;
      operand_a_q   <= '0;
      operand_b_q   <= '0;
      op_sel_q      <= '0;
      frame_valid_q <= 1'b0;
      frame_error_q <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      sclk_q        <= sclk_d;
      scs_q         <= scs_d;
      spico_q       <= spico_d;
      sop_q         <= sop_d;
      sclk_prev_q   <= sclk_prev_d;
      scs_prev_q    <= scs_prev_d;
      result_q      <= result_d;
      tx_q          <= tx_d;
      rx_q          <= rx_d;
      cnt_q         <= cnt_d;
      poci_q        <= poci_d;
      operand_a_q   <= operand_a_d;
      operand_b_q   <= operand_b_d;
      op_sel_q      <= op_sel_d;
      frame_valid_q <= frame_valid_d;
      frame_error_q <= frame_error_d;
      busy_q        <= busy_d;
    end
  end

  assign SPI_POCI    = poci_q;
  assign operand_a   = operand_a_q;
  assign operand_b   = operand_b_q;
  assign op_sel      = op_sel_q;
  assign frame_valid = frame_valid_q;
  assign frame_error = frame_error_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_spi_frame_slave.sv
// Directed bench for spi_frame_slave: vector table of full frames plus bypass, short, overlong and reset-mid-frame sequences.
module tb_spi_frame_slave;
  logic        sys_clock = 1'b0;
  logic        reset, SPI_CLK, SPI_PICO, SPI_CS, SPI_POCI;
  logic [2:0]  opcode, op_sel;
  logic        result_valid;
  logic [31:0] result_data, operand_a, operand_b;
  logic        frame_valid, frame_error, busy;

  always #5 sys_clock = ~sys_clock;

  spi_frame_slave #(.FRAME_BITS(64), .SYNC_STAGES(2)) dut (
    .sys_clock(sys_clock), .reset(reset), .SPI_CLK(SPI_CLK), .SPI_PICO(SPI_PICO),
    .SPI_CS(SPI_CS), .SPI_POCI(SPI_POCI), .opcode(opcode), .result_valid(result_valid),
    .result_data(result_data), .operand_a(operand_a), .operand_b(operand_b),
    .op_sel(op_sel), .frame_valid(frame_valid), .frame_error(frame_error), .busy(busy)
  );

  int checks = 0;
  int errors = 0;
  int fv_cnt = 0;
  int fe_cnt = 0;
  logic [70:0] snap;

  always @(negedge sys_clock) begin
    if (frame_valid === 1'b1) fv_cnt++;
    if (frame_error === 1'b1) fe_cnt++;
  end

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic pulse_result(input logic [31:0] val);
    @(negedge sys_clock);
    result_valid = 1'b1;
    result_data  = val;
    @(negedge sys_clock);
    result_valid = 1'b0;
  endtask

  // Bit i of the frame is d[127-i]; cap collects POCI sampled at each SPI_CLK rise.
  task automatic send_frame(input logic [127:0] d, input int nbits, input bit byp,
                            input logic [31:0] byp_val, input int rst_bit,
                            output logic [127:0] cap);
    cap = '0;
    @(negedge sys_clock);
    SPI_CS = 1'b0;
    if (byp) begin
      @(negedge sys_clock);
      @(negedge sys_clock);
      result_valid = 1'b1;
      result_data  = byp_val;
      @(negedge sys_clock);
      result_valid = 1'b0;
    end
    repeat (10) @(negedge sys_clock);
    for (int i = 0; i < nbits; i++) begin
      if (i == rst_bit) begin
        reset = 1'b1;
        repeat (2) @(negedge sys_clock);
        reset = 1'b0;
        @(negedge sys_clock);
        snap = {operand_a, operand_b, op_sel, busy, SPI_POCI, frame_valid, frame_error};
      end
      SPI_PICO = d[127-i];
      repeat (5) @(negedge sys_clock);
      SPI_CLK = 1'b1;
      cap = {cap[126:0], SPI_POCI};
      repeat (5) @(negedge sys_clock);
      SPI_CLK = 1'b0;
    end
    repeat (5) @(negedge sys_clock);
    SPI_CS = 1'b1;
    repeat (10) @(negedge sys_clock);
  endtask

  typedef struct {
    logic [63:0] frame;
    logic [2:0]  opc;
    bit          res_vld;
    logic [31:0] res;
    logic [31:0] exp_a;
    logic [31:0] exp_b;
    logic [2:0]  exp_op;
    logic [63:0] exp_poci;
  } vec_t;

  vec_t vecs[4];

  initial begin
    logic [127:0] cap;
    int fv0, fe0;

    vecs[0] = '{64'h430F8F5C_C2AEBDFE, 3'b000, 1'b0, 32'h0,
                32'h430F8F5C, 32'hC2AEBDFE, 3'b000, 64'h0};
    vecs[1] = '{64'h3F800000_40000000, 3'b101, 1'b1, 32'h42607DF4,
                32'h3F800000, 32'h40000000, 3'b101, 64'h00000000_42607DF4};
    vecs[2] = '{64'hFFFFFFFF_00000001, 3'b111, 1'b1, 32'hDEADBEEF,
                32'hFFFFFFFF, 32'h00000001, 3'b111, 64'h00000000_DEADBEEF};
    vecs[3] = '{64'h00000000_80000000, 3'b010, 1'b0, 32'h0,
                32'h00000000, 32'h80000000, 3'b010, 64'h00000000_DEADBEEF};

    reset        = 1'b1;
    SPI_CLK      = 1'b0;
    SPI_PICO     = 1'b0;
    SPI_CS       = 1'b1;
    opcode       = 3'b000;
    result_valid = 1'b0;
    result_data  = 32'h0;
    repeat (5) @(negedge sys_clock);
    chk("reset_outputs", {operand_a, operand_b, op_sel, busy, SPI_POCI, frame_valid, frame_error}, 71'h0);
    reset = 1'b0;
    repeat (5) @(negedge sys_clock);
    chk("post_reset_busy", busy, 1'b0);
    chk("post_reset_poci", SPI_POCI, 1'b0);

    for (int v = 0; v < 4; v++) begin
      opcode = vecs[v].opc;
      if (vecs[v].res_vld) pulse_result(vecs[v].res);
      fv0 = fv_cnt;
      fe0 = fe_cnt;
      send_frame({vecs[v].frame, 64'h0}, 64, 1'b0, 32'h0, -1, cap);
      chk($sformatf("v%0d_fv_count", v), fv_cnt - fv0, 1);
      chk($sformatf("v%0d_fe_count", v), fe_cnt - fe0, 0);
      chk($sformatf("v%0d_operand_a", v), operand_a, vecs[v].exp_a);
      chk($sformatf("v%0d_operand_b", v), operand_b, vecs[v].exp_b);
      chk($sformatf("v%0d_op_sel", v), op_sel, vecs[v].exp_op);
      chk($sformatf("v%0d_poci", v), cap[63:0], vecs[v].exp_poci);
      chk($sformatf("v%0d_busy_idle", v), busy, 1'b0);
    end

    // Result strobe coincident with the synchronised CS fall.
    opcode = 3'b001;
    fv0 = fv_cnt;
    send_frame({64'h40490FDB_BF800000, 64'h0}, 64, 1'b1, 32'h3F800000, -1, cap);
    chk("bypass_poci", cap[63:0], 64'h00000000_3F800000);
    chk("bypass_fv_count", fv_cnt - fv0, 1);
    chk("bypass_operand_a", operand_a, 32'h40490FDB);

    // Short frame: 40 bits then CS high.
    opcode = 3'b110;
    fv0 = fv_cnt;
    fe0 = fe_cnt;
    send_frame({64'hAAAAAAAA_55555555, 64'h0}, 40, 1'b0, 32'h0, -1, cap);
    chk("short_fe_count", fe_cnt - fe0, 1);
    chk("short_fv_count", fv_cnt - fv0, 0);
    chk("short_operand_a", operand_a, 32'h40490FDB);
    chk("short_operand_b", operand_b, 32'hBF800000);
    chk("short_op_sel", op_sel, 3'b001);
    chk("short_busy", busy, 1'b0);
    opcode = 3'b011;
    fv0 = fv_cnt;
    send_frame({64'h12345678_9ABCDEF0, 64'h0}, 64, 1'b0, 32'h0, -1, cap);
    chk("after_short_fv_count", fv_cnt - fv0, 1);
    chk("after_short_operands", {operand_a, operand_b}, 64'h12345678_9ABCDEF0);
    chk("after_short_op_sel", op_sel, 3'b011);

    // Overlong: 72 clocks, trailing 8 bits all ones must not disturb operands.
    opcode = 3'b110;
    fv0 = fv_cnt;
    fe0 = fe_cnt;
    send_frame({64'hCAFEBABE_0BADF00D, 8'hFF, 56'h0}, 72, 1'b0, 32'h0, -1, cap);
    chk("overlong_fv_count", fv_cnt - fv0, 1);
    chk("overlong_fe_count", fe_cnt - fe0, 0);
    chk("overlong_operands", {operand_a, operand_b}, 64'hCAFEBABE_0BADF00D);
    chk("overlong_op_sel", op_sel, 3'b110);
    chk("overlong_poci_frame", cap[71:8], 64'h00000000_3F800000);
    chk("overlong_poci_tail", cap[7:0], 8'h00);

    // Reset asserted after 20 bits and released with CS still low.
    opcode = 3'b111;
    fv0 = fv_cnt;
    fe0 = fe_cnt;
    send_frame({64'hFFFFFFFF_FFFFFFFF, 64'h0}, 64, 1'b0, 32'h0, 20, cap);
    chk("midreset_snapshot", snap, 71'h0);
    chk("midreset_fv_count", fv_cnt - fv0, 0);
    chk("midreset_fe_count", fe_cnt - fe0, 0);
    chk("midreset_outputs", {operand_a, operand_b, op_sel, busy}, 68'h0);
    opcode = 3'b100;
    fv0 = fv_cnt;
    send_frame({64'h01020304_05060708, 64'h0}, 64, 1'b0, 32'h0, -1, cap);
    chk("after_reset_fv_count", fv_cnt - fv0, 1);
    chk("after_reset_operands", {operand_a, operand_b}, 64'h01020304_05060708);
    chk("after_reset_op_sel", op_sel, 3'b100);
    chk("after_reset_poci", cap[63:0], 64'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
